// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Handshaked data-memory target with programmable latency,
//               little-endian byte/half/word/doubleword access and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_idx_w      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_count_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic [c_idx_w-1:0] w_index;
  logic [5:0]         w_shamt;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_err;
  logic [63:0]        w_word;
  logic [63:0]        w_shifted;
  logic [63:0]        w_load;
  logic [7:0]         w_bmask;
  logic [63:0]        w_wshift;
  logic [63:0]        w_merged;

  always_comb begin
    w_index        = r_addr[c_idx_w+2:3];
    w_shamt        = {r_addr[2:0], 3'b000};
    w_out_of_range = |r_addr[63:c_idx_w+3];
    case (r_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = r_addr[0];
      2'd2:    w_misaligned = |r_addr[1:0];
      default: w_misaligned = |r_addr[2:0];
    endcase
    w_err     = w_misaligned | w_out_of_range;
    w_word    = r_mem[w_index];
    w_shifted = w_word >> w_shamt;

    // Right-justified field, then zero or sign extension by size.
    case (r_size)
      2'd0:    w_load = r_unsigned ? {56'd0, w_shifted[7:0]}
                                   : {{56{w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load = r_unsigned ? {48'd0, w_shifted[15:0]}
                                   : {{48{w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load = r_unsigned ? {32'd0, w_shifted[31:0]}
                                   : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase

    case (r_size)
      2'd0:    w_bmask = 8'h01 << r_addr[2:0];
      2'd1:    w_bmask = 8'h03 << r_addr[2:0];
      2'd2:    w_bmask = 8'h0F << r_addr[2:0];
      default: w_bmask = 8'hFF;
    endcase
    w_wshift = r_wdata << w_shamt;
    w_merged = w_word;
    for (int b = 0; b < 8; b++) begin
      if (w_bmask[b]) w_merged[8*b +: 8] = w_wshift[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      r_count    <= 4'd0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_count    <= c_count_init;
            req_ready  <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            resp_err   <= w_err;
            resp_rdata <= (w_err || r_write) ? 64'd0 : w_load;
            if (r_write && !w_err) r_mem[w_index] <= w_merged;
            resp_valid <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Table-driven bench for data_mem_responder with multi-cycle
//               backpressure and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 64;
  localparam int LATENCY     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] model [DEPTH_WORDS];

  function automatic vec_t mk(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                              input logic uns, input logic [63:0] wd,
                              input logic [63:0] exp_rd, input logic exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.sz = sz; v.uns = uns; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; returns data, error and the edge count from acceptance to resp_valid.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd,
                         output logic [63:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_write = wr; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          guard;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          guard;

    for (int i = 0; i < DEPTH_WORDS; i++) model[i] = 64'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    @(negedge clk) reset = 1'b0;

    vecs.push_back(mk(1, 64'h10, 2'd3, 0, 64'h1122334455667788, 64'd0, 0, "st_d_10"));
    vecs.push_back(mk(0, 64'h10, 2'd3, 0, 64'd0, 64'h1122334455667788, 0, "ld_d_10"));
    vecs.push_back(mk(1, 64'h13, 2'd0, 0, 64'hFFFFFFFFFFFFFFAB, 64'd0, 0, "st_b_13"));
    vecs.push_back(mk(0, 64'h10, 2'd3, 0, 64'd0, 64'h11223344AB667788, 0, "ld_d_after_b"));
    vecs.push_back(mk(0, 64'h13, 2'd0, 0, 64'd0, 64'hFFFFFFFFFFFFFFAB, 0, "ld_b_s"));
    vecs.push_back(mk(0, 64'h13, 2'd0, 1, 64'd0, 64'h00000000000000AB, 0, "ld_b_u"));
    vecs.push_back(mk(1, 64'h14, 2'd2, 0, 64'h0000000080000001, 64'd0, 0, "st_w_14"));
    vecs.push_back(mk(0, 64'h14, 2'd2, 0, 64'd0, 64'hFFFFFFFF80000001, 0, "ld_w_s"));
    vecs.push_back(mk(0, 64'h14, 2'd2, 1, 64'd0, 64'h0000000080000001, 0, "ld_w_u"));
    vecs.push_back(mk(0, 64'h16, 2'd1, 0, 64'd0, 64'hFFFFFFFFFFFF8000, 0, "ld_h_s"));
    vecs.push_back(mk(0, 64'h16, 2'd1, 1, 64'd0, 64'h0000000000008000, 0, "ld_h_u"));
    vecs.push_back(mk(0, 64'h10, 2'd2, 0, 64'd0, 64'hFFFFFFFFAB667788, 0, "ld_w_s_10"));
    vecs.push_back(mk(0, 64'h11, 2'd1, 0, 64'd0, 64'd0, 1, "ld_h_misal"));
    vecs.push_back(mk(1, 64'h12, 2'd2, 0, 64'hFFFFFFFF, 64'd0, 1, "st_w_misal"));
    vecs.push_back(mk(1, 64'h200, 2'd3, 0, 64'hDEADBEEFDEADBEEF, 64'd0, 1, "st_d_oor"));
    vecs.push_back(mk(0, 64'h1_0000_0010, 2'd3, 0, 64'd0, 64'd0, 1, "ld_d_high"));
    vecs.push_back(mk(0, 64'h1F8, 2'd3, 0, 64'd0, 64'd0, 0, "ld_d_last"));
    vecs.push_back(mk(1, 64'h1FE, 2'd1, 0, 64'h000000000000BEEF, 64'd0, 0, "st_h_last"));
    vecs.push_back(mk(0, 64'h1F8, 2'd3, 0, 64'd0, 64'hBEEF000000000000, 0, "ld_d_last2"));
    vecs.push_back(mk(0, 64'h10, 2'd3, 0, 64'd0, 64'h80000001AB667788, 0, "ld_d_final"));

    foreach (vecs[k]) begin
      run_txn(vecs[k].wr, vecs[k].addr, vecs[k].sz, vecs[k].uns, vecs[k].wd, rd, er, lat);
      chk({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rd);
      chk({vecs[k].name, "_err"}, 64'(er), 64'(vecs[k].exp_err));
      chk({vecs[k].name, "_lat"}, 64'(lat), 64'(LATENCY));
    end

    // Whole-memory sweep confirms the rejected stores left everything else untouched.
    model[2]  = 64'h80000001AB667788;
    model[63] = 64'hBEEF000000000000;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      run_txn(1'b0, 64'(i * 8), 2'd3, 1'b0, 64'd0, rd, er, lat);
      chk($sformatf("sweep_%0d", i), rd, model[i]);
      chk($sformatf("sweep_err_%0d", i), 64'(er), 64'd0);
    end

    // Backpressure, with a stray store presented while busy.
    @(negedge clk);
    req_write = 1'b0; req_addr = 64'h10; req_size = 2'd3; req_unsigned = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk);
      #1 guard++;
    end
    chk("bp_resp_valid_rise", 64'(resp_valid), 64'd1);
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'h18; req_size = 2'd3; req_wdata = 64'hFFFFFFFFFFFFFFFF;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", resp_rdata, 64'h80000001AB667788);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_resp_valid", 64'(resp_valid), 64'd0);
    chk("bp_hs_req_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b0;
    run_txn(1'b0, 64'h18, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("stray_store_ignored", rd, 64'd0);

    // Reset while a store sits in WAIT.
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'h20; req_size = 2'd3; req_wdata = 64'hCAFEF00DCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_in_wait", 64'(req_ready), 64'd0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk) reset = 1'b0;
    run_txn(1'b0, 64'h20, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mid_rst_ld_20", rd, 64'd0);
    chk("mid_rst_ld_lat", 64'(lat), 64'(LATENCY));
    run_txn(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mid_rst_mem_cleared", rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
